// File: rtl/uart_tx_pkg.sv
// Shared UART definitions: oversampling, parity modes and transmitter state encoding.
// The receiver uses the same oversample constants so one baud enable serves both directions.
package uart_tx_pkg;

    localparam int unsigned OVERSAMPLE = 16;
    localparam int unsigned TICK_W     = 4;

    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_ODD  = 1;
    localparam int unsigned PAR_EVEN = 2;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } tx_state_e;

endpackage

// File: rtl/uart_tx_if.sv
// Write/status bundle between a host and the UART transmitter.
interface uart_tx_if;

    logic       wr_en;
    logic [7:0] din;
    logic       tx;
    logic       tx_ready;
    logic       tx_busy;
    logic       tx_done;
    logic       overrun;

    modport master (
        output wr_en, din,
        input  tx, tx_ready, tx_busy, tx_done, overrun
    );

    modport slave (
        input  wr_en, din,
        output tx, tx_ready, tx_busy, tx_done, overrun
    );

endinterface

// File: rtl/uart_tx.sv
// UART transmitter: start, DATA_BITS LSB-first, optional parity, STOP_BITS stop bits,
// with a one-entry holding register so frames can run back-to-back.
module uart_tx
    import uart_tx_pkg::*;
#(
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned PARITY    = PAR_NONE,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic     clk_50m,
    input  logic     rst_n,
    input  logic     clken,
    uart_tx_if.slave bus
);

    localparam logic [TICK_W-1:0] TickLast = TICK_W'(OVERSAMPLE - 1);
    localparam logic [7:0]        DataMask = 8'((16'd1 << DATA_BITS) - 16'd1);
    localparam logic [2:0]        LastData = 3'(DATA_BITS - 1);
    localparam logic [2:0]        LastStop = 3'(STOP_BITS - 1);

    tx_state_e         state_q, state_d;
    logic [TICK_W-1:0] tick_q, tick_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        shift_q, shift_d;
    logic              parity_q, parity_d;
    logic [7:0]        hold_q, hold_d;
    logic              hold_valid_q, hold_valid_d;
    logic              tx_q, tx_d;
    logic              tx_done_q, tx_done_d;
    logic              overrun_q, overrun_d;
    logic              bit_end;
    logic              load;

    assign bit_end = (tick_q == TickLast);

    always_comb begin
        state_d      = state_q;
        tick_d       = tick_q;
        bit_d        = bit_q;
        shift_d      = shift_q;
        parity_d     = parity_q;
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        overrun_d    = overrun_q;
        tx_done_d    = 1'b0;
        load         = 1'b0;

        if (bus.wr_en) begin
            if (hold_valid_q) begin
                overrun_d = 1'b1;
            end else begin
                hold_d       = bus.din;
                hold_valid_d = 1'b1;
            end
        end

        if (clken) begin
            tick_d = tick_q + TICK_W'(1);
            case (state_q)
                StIdle: begin
                    tick_d = '0;
                    load   = hold_valid_q;
                end
                StStart: begin
                    if (bit_end) begin
                        state_d = StData;
                        bit_d   = '0;
                    end
                end
                StData: begin
                    if (bit_end) begin
                        parity_d = parity_q ^ shift_q[0];
                        shift_d  = shift_q >> 1;
                        if (bit_q == LastData) begin
                            bit_d   = '0;
                            state_d = (PARITY != PAR_NONE) ? StParity : StStop;
                        end else begin
                            bit_d = bit_q + 3'd1;
                        end
                    end
                end
                StParity: begin
                    if (bit_end) begin
                        state_d = StStop;
                        bit_d   = '0;
                    end
                end
                StStop: begin
                    if (bit_end) begin
                        if (bit_q == LastStop) begin
                            tx_done_d = 1'b1;
                            bit_d     = '0;
                            if (hold_valid_q) begin
                                load = 1'b1;
                            end else begin
                                state_d = StIdle;
                            end
                        end else begin
                            bit_d = bit_q + 3'd1;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        // Load consumes the old holding value; a same-edge write was already rejected above.
        if (load) begin
            shift_d      = hold_q & DataMask;
            parity_d     = (PARITY == PAR_ODD);
            hold_valid_d = 1'b0;
            state_d      = StStart;
            tick_d       = '0;
        end

        case (state_d)
            StStart:  tx_d = 1'b0;
            StData:   tx_d = shift_d[0];
            StParity: tx_d = parity_d;
            default:  tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            tick_q       <= '0;
            bit_q        <= '0;
            shift_q      <= '0;
            parity_q     <= 1'b0;
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
            tx_q         <= 1'b1;
            tx_done_q    <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            tick_q       <= tick_d;
            bit_q        <= bit_d;
            shift_q      <= shift_d;
            parity_q     <= parity_d;
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
            tx_q         <= tx_d;
            tx_done_q    <= tx_done_d;
            overrun_q    <= overrun_d;
        end
    end

    assign bus.tx       = tx_q;
    assign bus.tx_ready = !hold_valid_q;
    assign bus.tx_busy  = (state_q != StIdle);
    assign bus.tx_done  = tx_done_q;
    assign bus.overrun  = overrun_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: three configurations (8N1, 8E2, 5O1) share stimulus and are compared
// every cycle against a frame-level line model built from the framing rules.
module tb_uart_tx;

    logic       clk_50m = 1'b0;
    logic       rst_n;
    logic       clken;
    logic       wr_en;
    logic [7:0] din;

    int n_vec = 0;
    int n_err = 0;

    uart_tx_if bus0 ();
    uart_tx_if bus1 ();
    uart_tx_if bus2 ();

    assign bus0.wr_en = wr_en;
    assign bus0.din   = din;
    assign bus1.wr_en = wr_en;
    assign bus1.din   = din;
    assign bus2.wr_en = wr_en;
    assign bus2.din   = din;

    uart_tx #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_dut0 (
        .clk_50m(clk_50m), .rst_n(rst_n), .clken(clken), .bus(bus0.slave)
    );
    uart_tx #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(2)) u_dut1 (
        .clk_50m(clk_50m), .rst_n(rst_n), .clken(clken), .bus(bus1.slave)
    );
    uart_tx #(.DATA_BITS(5), .PARITY(1), .STOP_BITS(1)) u_dut2 (
        .clk_50m(clk_50m), .rst_n(rst_n), .clken(clken), .bus(bus2.slave)
    );

    logic [2:0] tx_o, rdy_o, busy_o, done_o, ovr_o;
    assign tx_o   = {bus2.tx,       bus1.tx,       bus0.tx};
    assign rdy_o  = {bus2.tx_ready, bus1.tx_ready, bus0.tx_ready};
    assign busy_o = {bus2.tx_busy,  bus1.tx_busy,  bus0.tx_busy};
    assign done_o = {bus2.tx_done,  bus1.tx_done,  bus0.tx_done};
    assign ovr_o  = {bus2.overrun,  bus1.overrun,  bus0.overrun};

    always #10 clk_50m = ~clk_50m;

    // Reference model: pending byte, plus the current frame as a list of bit levels.
    logic       m_hv   [3];
    logic [7:0] m_hold [3];
    logic       m_ovr  [3];
    logic       m_act  [3];
    logic       m_tx   [3];
    logic       m_done [3];
    int         m_pos  [3];
    int         m_len  [3];
    logic       m_bits [3][12];

    function automatic int cfg_db(input int k);
        return (k == 2) ? 5 : 8;
    endfunction

    function automatic int cfg_par(input int k);
        case (k)
            0:       return 0;
            1:       return 2;
            default: return 1;
        endcase
    endfunction

    function automatic int cfg_sb(input int k);
        return (k == 1) ? 2 : 1;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_hv[k]   = 1'b0;
            m_hold[k] = 8'h00;
            m_ovr[k]  = 1'b0;
            m_act[k]  = 1'b0;
            m_tx[k]   = 1'b1;
            m_done[k] = 1'b0;
            m_pos[k]  = 0;
            m_len[k]  = 0;
        end
    endtask

    task automatic model_edge(input int k);
        logic       acc;
        logic [7:0] dat;
        int         nb;
        m_done[k] = 1'b0;
        acc = wr_en && !m_hv[k];
        if (wr_en && m_hv[k]) m_ovr[k] = 1'b1;
        if (clken) begin
            if (m_pos[k] == m_len[k]) begin
                if (m_act[k]) begin
                    m_done[k] = 1'b1;
                    m_act[k]  = 1'b0;
                end
                if (m_hv[k]) begin
                    dat = m_hold[k] & 8'((1 << cfg_db(k)) - 1);
                    m_bits[k][0] = 1'b0;
                    for (int i = 0; i < cfg_db(k); i++) m_bits[k][1 + i] = dat[i];
                    nb = 1 + cfg_db(k);
                    if (cfg_par(k) == 1) begin
                        m_bits[k][nb] = ~^dat;
                        nb++;
                    end else if (cfg_par(k) == 2) begin
                        m_bits[k][nb] = ^dat;
                        nb++;
                    end
                    for (int i = 0; i < cfg_sb(k); i++) begin
                        m_bits[k][nb] = 1'b1;
                        nb++;
                    end
                    m_len[k] = 16 * nb;
                    m_pos[k] = 0;
                    m_hv[k]  = 1'b0;
                    m_act[k] = 1'b1;
                end
            end
            if (m_pos[k] < m_len[k]) begin
                m_tx[k] = m_bits[k][m_pos[k] / 16];
                m_pos[k]++;
            end else begin
                m_tx[k] = 1'b1;
            end
        end
        if (acc) begin
            m_hold[k] = din;
            m_hv[k]   = 1'b1;
        end
    endtask

    task automatic check_all(input string ph);
        for (int k = 0; k < 3; k++) begin
            check_eq($sformatf("%s tx[%0d]", ph, k),       tx_o[k],   m_tx[k]);
            check_eq($sformatf("%s tx_ready[%0d]", ph, k), rdy_o[k],  !m_hv[k]);
            check_eq($sformatf("%s tx_busy[%0d]", ph, k),  busy_o[k], m_act[k]);
            check_eq($sformatf("%s tx_done[%0d]", ph, k),  done_o[k], m_done[k]);
            check_eq($sformatf("%s overrun[%0d]", ph, k),  ovr_o[k],  m_ovr[k]);
        end
    endtask

    // ck: 0 = clken low, 1 = clken high, 2 = random (about one edge in three)
    task automatic step(input logic w, input logic [7:0] d, input int ck);
        wr_en = w;
        din   = d;
        clken = (ck == 1) || ((ck == 2) && ($urandom_range(0, 2) == 0));
        @(posedge clk_50m);
        for (int k = 0; k < 3; k++) model_edge(k);
        #1;
        check_all("run");
    endtask

    task automatic drain();
        for (int i = 0; i < 4000 && (m_act[0] || m_act[1] || m_act[2] || m_hv[0] || m_hv[1] || m_hv[2]); i++)
            step(1'b0, 8'h00, 2);
        check_eq("drain busy", busy_o, 3'b000);
    endtask

    task automatic wait_hold_empty();
        for (int i = 0; i < 2000 && (m_hv[0] || m_hv[1] || m_hv[2]); i++)
            step(1'b0, 8'h00, 2);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        clken = 1'b0;
        wr_en = 1'b0;
        din   = 8'h00;
        model_reset();
        #25;
        check_all("reset");
        @(posedge clk_50m);
        #1;
        rst_n = 1'b1;

        // Single frames from idle, including the parity example byte
        step(1'b1, 8'h55, 0);
        drain();
        step(1'b1, 8'h07, 0);
        drain();

        // Back-to-back frames: second write lands once the first has moved to the shifter
        step(1'b1, 8'hA5, 2);
        wait_hold_empty();
        step(1'b1, 8'h3C, 2);
        drain();

        // Overrun: 0x11 loads, 0x22 fills the holding register, 0x33 is dropped
        step(1'b1, 8'h11, 0);
        step(1'b0, 8'h00, 1);
        step(1'b1, 8'h22, 0);
        step(1'b1, 8'h33, 0);
        drain();
        for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 2);

        // Reset in the middle of the data bits of 0xF0
        step(1'b1, 8'hF0, 2);
        for (int i = 0; i < 2000 && m_pos[0] < 72; i++) step(1'b0, 8'h00, 2);
        #4;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        @(posedge clk_50m);
        #1;
        check_all("rst_hold");
        rst_n = 1'b1;
        step(1'b1, 8'h0F, 2);
        drain();

        // Writes accepted while clken is held low; line stays frozen
        step(1'b1, 8'h99, 0);
        for (int i = 0; i < 20; i++) step(1'b0, 8'h00, 0);
        drain();

        // Random traffic
        for (int i = 0; i < 5000; i++)
            step(($urandom_range(0, 99) == 0), 8'($urandom), 2);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
